// File: rtl/game_layer_renderer_if.sv
// Pixel, sprite and brick-write bus between the SVGA/game logic side and the renderer.
// Widths must match the renderer's geometry parameters.
interface game_layer_renderer_if #(
  parameter int COLOR_W = 8,
  parameter int COL_W   = 4,
  parameter int ROW_W   = 3,
  parameter int CNT_W   = 7
);
  logic [9:0]         X_PIXEL;
  logic [9:0]         Y_PIXEL;
  logic [9:0]         PADDLE_X_PIXEL;
  logic [9:0]         BALL_X_PIXEL;
  logic [9:0]         BALL_Y_PIXEL;
  logic               BRICK_WE;
  logic [COL_W-1:0]   BRICK_COL;
  logic [ROW_W-1:0]   BRICK_ROW;
  logic               BRICK_SET;
  logic               REFILL_REQ;
  logic [COLOR_W-1:0] COLOR;
  logic               FRAME_DONE;
  logic               REFILL_BUSY;
  logic [CNT_W-1:0]   BRICKS_LEFT;

  modport master (
    output X_PIXEL, Y_PIXEL, PADDLE_X_PIXEL, BALL_X_PIXEL, BALL_Y_PIXEL,
    output BRICK_WE, BRICK_COL, BRICK_ROW, BRICK_SET, REFILL_REQ,
    input  COLOR, FRAME_DONE, REFILL_BUSY, BRICKS_LEFT
  );

  modport slave (
    input  X_PIXEL, Y_PIXEL, PADDLE_X_PIXEL, BALL_X_PIXEL, BALL_Y_PIXEL,
    input  BRICK_WE, BRICK_COL, BRICK_ROW, BRICK_SET, REFILL_REQ,
    output COLOR, FRAME_DONE, REFILL_BUSY, BRICKS_LEFT
  );
endinterface

// File: rtl/game_layer_renderer.sv
// Breakout playfield renderer: housing, paddle, ball and a writable brick wall with vblank refill.
// Latency: 2 cycles from pixel coordinate to COLOR; FRAME_DONE 1 cycle after the reference pixel.
// Backpressure: none, free-running pixel pipeline; refill waits for the next frame boundary.
module game_layer_renderer #(
  parameter int                 COLOR_W         = 8,
  parameter int                 V_ACTIVE        = 600,
  parameter int                 TILE_SHIFT      = 3,
  parameter int                 CEIL_Y_TILE     = 2,
  parameter int                 LEFT_WALL_TILE  = 2,
  parameter int                 RIGHT_WALL_TILE = 97,
  parameter int                 PADDLE_Y_TILE   = 70,
  parameter int                 PADDLE_LEN      = 64,
  parameter int                 BALL_SIZE       = 8,
  parameter int                 BRICK_COLS      = 12,
  parameter int                 BRICK_ROWS      = 6,
  parameter int                 BRICK_X0_TILE   = 4,
  parameter int                 BRICK_Y0_TILE   = 8,
  parameter int                 BRICK_W_TILES   = 7,
  parameter int                 BRICK_H_TILES   = 2,
  parameter logic [COLOR_W-1:0] COL_HOUSING     = '1,
  parameter logic [COLOR_W-1:0] COL_PADDLE      = '1,
  parameter logic [COLOR_W-1:0] COL_BALL        = '1,
  parameter logic [COLOR_W-1:0] COL_BRICK0      = 8'hE0
) (
  input logic             CLK,
  input logic             RST_N,
  game_layer_renderer_if.slave bus
);

  localparam int COL_W = $clog2(BRICK_COLS);
  localparam int ROW_W = $clog2(BRICK_ROWS);
  localparam int CNT_W = $clog2(BRICK_COLS * BRICK_ROWS + 1);

  localparam logic [9:0] CEIL_T = 10'(CEIL_Y_TILE);
  localparam logic [9:0] LW_T   = 10'(LEFT_WALL_TILE);
  localparam logic [9:0] RW_T   = 10'(RIGHT_WALL_TILE);
  localparam logic [9:0] PAD_T  = 10'(PADDLE_Y_TILE);
  localparam logic [9:0] BX0_T  = 10'(BRICK_X0_TILE);
  localparam logic [9:0] BX1_T  = 10'(BRICK_X0_TILE + BRICK_COLS * BRICK_W_TILES);
  localparam logic [9:0] BY0_T  = 10'(BRICK_Y0_TILE);
  localparam logic [9:0] BY1_T  = 10'(BRICK_Y0_TILE + BRICK_ROWS * BRICK_H_TILES);
  localparam logic [9:0] BW_T   = 10'(BRICK_W_TILES);
  localparam logic [9:0] BH_T   = 10'(BRICK_H_TILES);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BRICK_COLS * BRICK_ROWS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BRICK_ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_PENDING, S_FILL} state_t;

  state_t                               state_q, state_d;
  logic [ROW_W-1:0]                     row_cnt_q, row_cnt_d;
  logic [BRICK_ROWS-1:0][BRICK_COLS-1:0] bitmap_q, bitmap_d;
  logic [CNT_W-1:0]                     bricks_left_q, bricks_left_d;
  logic                                 frame_done_q, frame_done_d;

  logic [9:0]         tile_x_q, tile_x_d, tile_y_q, tile_y_d;
  logic [9:0]         rel_x, rel_y;
  logic               in_brick_q, in_brick_d;
  logic [COL_W-1:0]   brick_col_q, brick_col_d;
  logic [ROW_W-1:0]   brick_row_q, brick_row_d;
  logic               paddle_hit_q, paddle_hit_d;
  logic               ball_hit_q, ball_hit_d;
  logic               housing_hit, brick_hit;
  logic [COLOR_W-1:0] color_q, color_d;

  // Stage 1: tile decode and sprite hits; 11-bit sums keep sprites near 1023 from wrapping.
  always_comb begin
    tile_x_d = bus.X_PIXEL >> TILE_SHIFT;
    tile_y_d = bus.Y_PIXEL >> TILE_SHIFT;
    rel_x    = tile_x_d - BX0_T;
    rel_y    = tile_y_d - BY0_T;
    in_brick_d = (tile_x_d >= BX0_T) && (tile_x_d < BX1_T) &&
                 (tile_y_d >= BY0_T) && (tile_y_d < BY1_T) &&
                 ((rel_x % BW_T) != (BW_T - 10'd1)) &&
                 ((rel_y % BH_T) != (BH_T - 10'd1));
    brick_col_d = '0;
    brick_row_d = '0;
    if (in_brick_d) begin
      brick_col_d = COL_W'(rel_x / BW_T);
      brick_row_d = ROW_W'(rel_y / BH_T);
    end
    paddle_hit_d = (tile_y_d == PAD_T) &&
                   ({1'b0, bus.X_PIXEL} >= {1'b0, bus.PADDLE_X_PIXEL}) &&
                   ({1'b0, bus.X_PIXEL} < ({1'b0, bus.PADDLE_X_PIXEL} + 11'(PADDLE_LEN)));
    ball_hit_d = ({1'b0, bus.X_PIXEL} >= {1'b0, bus.BALL_X_PIXEL}) &&
                 ({1'b0, bus.X_PIXEL} < ({1'b0, bus.BALL_X_PIXEL} + 11'(BALL_SIZE))) &&
                 ({1'b0, bus.Y_PIXEL} >= {1'b0, bus.BALL_Y_PIXEL}) &&
                 ({1'b0, bus.Y_PIXEL} < ({1'b0, bus.BALL_Y_PIXEL} + 11'(BALL_SIZE)));
    frame_done_d = (bus.X_PIXEL == 10'd0) && (bus.Y_PIXEL == 10'(V_ACTIVE));
  end

  // Stage 2 reads bitmap_q, so a write landing on the same edge is not yet visible.
  always_comb begin
    housing_hit = ((tile_y_q == CEIL_T) && (tile_x_q >= LW_T) && (tile_x_q <= RW_T)) ||
                  ((tile_y_q > CEIL_T) && ((tile_x_q == LW_T) || (tile_x_q == RW_T)));
    brick_hit = in_brick_q && bitmap_q[brick_row_q][brick_col_q];
    color_d = '0;
    if (ball_hit_q)        color_d = COL_BALL;
    else if (paddle_hit_q) color_d = COL_PADDLE;
    else if (housing_hit)  color_d = COL_HOUSING;
    else if (brick_hit)    color_d = COL_BRICK0 + COLOR_W'(brick_row_q);
  end

  // Fill is applied after the game write so a same-row collision leaves the brick present.
  always_comb begin
    bitmap_d = bitmap_q;
    if (bus.BRICK_WE && (int'(bus.BRICK_COL) < BRICK_COLS) && (int'(bus.BRICK_ROW) < BRICK_ROWS)) begin
      bitmap_d[bus.BRICK_ROW][bus.BRICK_COL] = bus.BRICK_SET;
    end
    if (state_q == S_FILL) begin
      bitmap_d[row_cnt_q] = '1;
    end
    bricks_left_d = CNT_W'($countones(bitmap_d));
  end

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.REFILL_REQ) state_d = S_PENDING;
      end
      S_PENDING: begin
        if (frame_done_q) begin
          state_d   = S_FILL;
          row_cnt_d = '0;
        end
      end
      S_FILL: begin
        if (row_cnt_q == LAST_ROW) begin
          state_d   = S_IDLE;
          row_cnt_d = '0;
        end else begin
          row_cnt_d = row_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= S_IDLE;
      row_cnt_q     <= '0;
      bitmap_q      <= '1;
      bricks_left_q <= FULL_CNT;
      frame_done_q  <= 1'b0;
      tile_x_q      <= '0;
      tile_y_q      <= '0;
      in_brick_q    <= 1'b0;
      brick_col_q   <= '0;
      brick_row_q   <= '0;
      paddle_hit_q  <= 1'b0;
      ball_hit_q    <= 1'b0;
      color_q       <= '0;
    end else begin
      state_q       <= state_d;
      row_cnt_q     <= row_cnt_d;
      bitmap_q      <= bitmap_d;
      bricks_left_q <= bricks_left_d;
      frame_done_q  <= frame_done_d;
      tile_x_q      <= tile_x_d;
      tile_y_q      <= tile_y_d;
      in_brick_q    <= in_brick_d;
      brick_col_q   <= brick_col_d;
      brick_row_q   <= brick_row_d;
      paddle_hit_q  <= paddle_hit_d;
      ball_hit_q    <= ball_hit_d;
      color_q       <= color_d;
    end
  end

  assign bus.COLOR       = color_q;
  assign bus.FRAME_DONE  = frame_done_q;
  assign bus.REFILL_BUSY = (state_q != S_IDLE);
  assign bus.BRICKS_LEFT = bricks_left_q;

endmodule
